// File: rtl/vpi_adder_pkg.sv
//======================================================================
// Module : vpi_adder_pkg
// Brief  : Shared mode encoding and channel-width helper for vpi_adder_pipe.
// Rev    : 1.0  initial release
//======================================================================
`default_nettype none

package vpi_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ACC = 2'd2,
        MODE_CLR = 2'd3
    } mode_e;

    // Channel index is at least one bit wide, even for a single channel.
    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vpi_acc_bank.sv
//======================================================================
// Module : vpi_acc_bank
// Brief  : NCH x (W+1) accumulator registers, one read and one write port.
//          VPI_ADDER_ACC_SAT_EN makes the accumulate sum saturate.
// Rev    : 1.0  initial release
//======================================================================
`default_nettype none

module vpi_acc_bank
    import vpi_adder_pkg::*;
#(
    parameter int W   = 8,
    parameter int NCH = 4,
    parameter int CHW = chw_of(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CHW-1:0] rd_ch,
    input  logic [W-1:0]   add_val,
    output logic [W:0]     rd_data,
    output logic [W:0]     acc_sum,
`ifdef VPI_ADDER_ACC_SAT_EN
    output logic           acc_sat,
`endif
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W:0]     wr_data
);

    logic [W:0] r_acc [NCH];

    // Out-of-range channels read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) begin
                rd_data = r_acc[i];
            end
        end
    end

`ifdef VPI_ADDER_ACC_SAT_EN
    logic [W+1:0] w_ext;
    assign w_ext   = {1'b0, rd_data} + {2'b00, add_val};
    assign acc_sat = w_ext[W+1];
    assign acc_sum = w_ext[W+1] ? {(W+1){1'b1}} : w_ext[W:0];
`else
    assign acc_sum = rd_data + {1'b0, add_val};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ch == CHW'(i)) begin
                    r_acc[i] <= wr_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vpi_adder_pipe.sv
//======================================================================
// Module : vpi_adder_pipe
// Brief  : Two-stage valid/ready add/sub/accumulate/clear pipeline with
//          per-channel accumulators and a completion counter.
//          VPI_ADDER_ACC_SAT_EN enables ACC saturation and the acc_sat port.
// Rev    : 1.0  initial release
//======================================================================
`default_nettype none

module vpi_adder_pipe
    import vpi_adder_pkg::*;
#(
    parameter int W    = 8,
    parameter int NCH  = 4,
    parameter int CHW  = chw_of(NCH),
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [CHW-1:0]  in_ch,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_mode,
    output logic [CHW-1:0]  out_ch,
    output logic [W:0]      out_sum,
`ifdef VPI_ADDER_ACC_SAT_EN
    output logic            acc_sat,
`endif
    output logic [CNTW-1:0] txn_cnt
);

    localparam logic [CHW:0] c_nch = (CHW+1)'(NCH);

    logic           r_s1_valid;
    mode_e          r_s1_mode;
    logic [CHW-1:0] r_s1_ch;
    logic [W-1:0]   r_s1_a;
    logic [W-1:0]   r_s1_b;

    logic           w_adv;
    logic           w_accept;
    logic           w_move;
    logic           w_ch_ok;
    logic [W:0]     w_rd_data;
    logic [W:0]     w_acc_sum;
    logic [W:0]     w_result;
    logic           w_wr_en;
    logic [W:0]     w_wr_data;
`ifdef VPI_ADDER_ACC_SAT_EN
    logic           w_bank_sat;
    logic           w_sat;
`endif

    // in_ready depends only on registered state, out_ready and reset.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = rst_n && (!r_s1_valid || w_adv);
    assign w_accept = in_valid && in_ready;
    assign w_move   = r_s1_valid && w_adv;
    assign w_ch_ok  = ({1'b0, r_s1_ch} < c_nch);

    vpi_acc_bank #(
        .W   (W),
        .NCH (NCH),
        .CHW (CHW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_ch   (r_s1_ch),
        .add_val (r_s1_a),
        .rd_data (w_rd_data),
        .acc_sum (w_acc_sum),
`ifdef VPI_ADDER_ACC_SAT_EN
        .acc_sat (w_bank_sat),
`endif
        .wr_en   (w_wr_en),
        .wr_ch   (r_s1_ch),
        .wr_data (w_wr_data)
    );

    // Bad channel on ACC/CLR yields 0 and leaves the bank untouched.
    always_comb begin
        w_result  = '0;
        w_wr_en   = 1'b0;
        w_wr_data = '0;
`ifdef VPI_ADDER_ACC_SAT_EN
        w_sat     = 1'b0;
`endif
        case (r_s1_mode)
            MODE_ADD: w_result = {1'b0, r_s1_a} + {1'b0, r_s1_b};
            MODE_SUB: w_result = {1'b0, r_s1_a} - {1'b0, r_s1_b};
            MODE_ACC: begin
                if (w_ch_ok) begin
                    w_result  = w_acc_sum;
                    w_wr_en   = w_move;
                    w_wr_data = w_acc_sum;
`ifdef VPI_ADDER_ACC_SAT_EN
                    w_sat     = w_bank_sat;
`endif
                end
            end
            MODE_CLR: begin
                if (w_ch_ok) begin
                    w_result = w_rd_data;
                    w_wr_en  = w_move;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_ADD;
            r_s1_ch    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            out_valid  <= 1'b0;
            out_mode   <= '0;
            out_ch     <= '0;
            out_sum    <= '0;
`ifdef VPI_ADDER_ACC_SAT_EN
            acc_sat    <= 1'b0;
`endif
            txn_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_mode  <= mode_e'(in_mode);
                r_s1_ch    <= in_ch;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_adv) begin
                out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    out_mode <= r_s1_mode;
                    out_ch   <= r_s1_ch;
                    out_sum  <= w_result;
`ifdef VPI_ADDER_ACC_SAT_EN
                    acc_sat  <= w_sat;
`endif
                end
            end

            if (out_valid && out_ready) begin
                txn_cnt <= txn_cnt + CNTW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vpi_adder_pipe.sv
//======================================================================
// Module : tb_vpi_adder_pipe
// Brief  : Self-checking bench for vpi_adder_pipe (W=8, NCH=4), vector
//          table plus scoreboard, honours VPI_ADDER_ACC_SAT_EN.
// Rev    : 1.0  initial release
//======================================================================
`default_nettype none

module tb_vpi_adder_pipe;

    localparam logic [1:0] M_ADD = 2'd0;
    localparam logic [1:0] M_SUB = 2'd1;
    localparam logic [1:0] M_ACC = 2'd2;
    localparam logic [1:0] M_CLR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'd0;
    logic [1:0]  in_ch = 2'd0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_mode;
    logic [1:0]  out_ch;
    logic [8:0]  out_sum;
    logic [31:0] txn_cnt;
`ifdef VPI_ADDER_ACC_SAT_EN
    logic        acc_sat;
`endif

    vpi_adder_pipe #(.W(8), .NCH(4), .CNTW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_ch     (in_ch),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_ch    (out_ch),
        .out_sum   (out_sum),
`ifdef VPI_ADDER_ACC_SAT_EN
        .acc_sat   (acc_sat),
`endif
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] ch;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
        logic       sat;
    } vec_t;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] ch;
        logic [8:0] sum;
        logic       sat;
    } exp_t;

    exp_t q[$];
    int   out_cyc[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every completed output handshake against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(out_sum), 64'h1_0000);
                end else begin
                    e = q.pop_front();
                    check("out_sum", 64'(out_sum), 64'(e.sum));
                    check("out_mode_ch", 64'({out_mode, out_ch}), 64'({e.mode, e.ch}));
`ifdef VPI_ADDER_ACC_SAT_EN
                    check("acc_sat", 64'(acc_sat), 64'(e.sat));
`endif
                end
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [1:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic [8:0] s, input logic st);
        exp_t e;
        bit   done;
        e.mode = m; e.ch = c; e.sum = s; e.sat = st;
        in_mode = m; in_ch = c; in_a = a; in_b = b; in_valid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end
            step();
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (q.size() == 0 && !out_valid) done = 1'b1;
            else step();
        end
        if (!done) check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    vec_t tbl[15];
    logic [8:0] sat_v2;
    logic [8:0] sat_v3;
    logic       sat_f;

    initial begin
        int base;
        logic [7:0] ba, bb;
        logic [8:0] first_sum;

`ifdef VPI_ADDER_ACC_SAT_EN
        sat_v2 = 9'h1FF; sat_v3 = 9'h1FF; sat_f = 1'b1;
`else
        sat_v2 = 9'h0FD; sat_v3 = 9'h0FD; sat_f = 1'b0;
`endif
        tbl[0]  = '{M_ADD, 2'd0, 8'hFF, 8'h01, 9'h100, 1'b0};
        tbl[1]  = '{M_SUB, 2'd1, 8'h03, 8'h05, 9'h1FE, 1'b0};
        tbl[2]  = '{M_ADD, 2'd3, 8'h80, 8'h80, 9'h100, 1'b0};
        tbl[3]  = '{M_SUB, 2'd0, 8'h05, 8'h03, 9'h002, 1'b0};
        tbl[4]  = '{M_ADD, 2'd2, 8'h00, 8'h00, 9'h000, 1'b0};
        tbl[5]  = '{M_ACC, 2'd2, 8'd10, 8'h00, 9'd10,  1'b0};
        tbl[6]  = '{M_ACC, 2'd2, 8'd20, 8'h00, 9'd30,  1'b0};
        tbl[7]  = '{M_ACC, 2'd2, 8'd30, 8'h00, 9'd60,  1'b0};
        tbl[8]  = '{M_CLR, 2'd2, 8'h00, 8'h00, 9'd60,  1'b0};
        tbl[9]  = '{M_ACC, 2'd2, 8'd1,  8'h00, 9'd1,   1'b0};
        tbl[10] = '{M_CLR, 2'd0, 8'h00, 8'h00, 9'd0,   1'b0};
        tbl[11] = '{M_ACC, 2'd1, 8'hFF, 8'h00, 9'd255, 1'b0};
        tbl[12] = '{M_ACC, 2'd1, 8'hFF, 8'h00, 9'd510, 1'b0};
        tbl[13] = '{M_ACC, 2'd1, 8'hFF, 8'h00, sat_v2, sat_f};
        tbl[14] = '{M_CLR, 2'd1, 8'h00, 8'h00, sat_v3, 1'b0};

        // Reset held two cycles with a pending request.
        rst_n = 1'b0; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_txn_cnt", 64'(txn_cnt), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
        end
        check("rst_out_sum", 64'(out_sum), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_release", 64'(in_ready), 64'd1);

        // Latency: accepted at edge N, out_valid visible after edge N+1.
        send(M_ADD, 2'd0, 8'hFF, 8'h01, 9'h100, 1'b0);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        step();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_sum", 64'(out_sum), 64'h100);
        drain();

        // Vector table, issued back-to-back.
        base = out_cyc.size();
        foreach (tbl[i]) send(tbl[i].mode, tbl[i].ch, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].sat);
        drain();
        check("tbl_count", 64'(out_cyc.size() - base), 64'd15);
        if (out_cyc.size() - base == 15)
            check("tbl_back_to_back", 64'(out_cyc[base+14] - out_cyc[base]), 64'd14);
        check("txn_after_tbl", 64'(txn_cnt), 64'd16);

        // Backpressure: six ADDs with out_ready low for four cycles.
        do_reset();
        out_ready = 1'b0;
        first_sum = 9'({1'b0, 8'hF8} + {1'b0, 8'd5});
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ba = 8'(8'hF8 + 2 * i);
                    bb = 8'(5 + i);
                    send(M_ADD, 2'(i), ba, bb, {1'b0, ba} + {1'b0, bb}, 1'b0);
                end
            end
            begin
                step(); step();
                check("bp_sum_early", 64'(out_sum), 64'(first_sum));
                step(); step();
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_sum_held", 64'(out_sum), 64'(first_sum));
                check("bp_txn_held", 64'(txn_cnt), 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_txn_cnt", 64'(txn_cnt), 64'd6);

        // Mid-flight reset discards in-flight work and clears accumulators.
        out_ready = 1'b0;
        send(M_ACC, 2'd3, 8'd7, 8'd0, 9'd7, 1'b0);
        send(M_ACC, 2'd0, 8'd5, 8'd0, 9'd5, 1'b0);
        rst_n = 1'b0;
        q.delete();
        step();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_txn_cnt", 64'(txn_cnt), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("mid_rst_no_output", 64'(out_valid), 64'd0);
        send(M_CLR, 2'd3, 8'd0, 8'd0, 9'd0, 1'b0);
        send(M_CLR, 2'd0, 8'd0, 8'd0, 9'd0, 1'b0);
        drain();
        check("mid_rst_txn_after", 64'(txn_cnt), 64'd2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vpi_adder_pipe.md
Name: vpi_adder_pipe

Overview:
- Parametrised, multi-channel, pipelined successor to the simple combinational 8-bit + 8-bit → 9-bit test adder.
- Adds a valid/ready handshake, per-channel accumulators, add/sub/accumulate/clear modes, and a completion counter.
- Serves as the standard DUT target driven from the pyvpi Python harness.
- Instantiated inside a test top alongside the free-running clk generator.

Parameters:
- W, 8, operand width; results are W+1 bits.
- NCH, 4, number of accumulator channels (≥1).
- CHW, $clog2(NCH) (min 1), channel index width.
- CNTW, 32, width of the completed-transaction counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_mode  in  2  0=ADD, 1=SUB, 2=ACC, 3=CLR.
- in_ch  in  CHW  channel index (ACC/CLR only; ignored for ADD/SUB).
- in_a  in  W  operand A.
- in_b  in  W  operand B (ADD/SUB only).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_mode  out  2  echoed mode.
- out_ch  out  CHW  echoed channel.
- out_sum  out  W+1  result.
- txn_cnt  out  CNTW  completed output handshakes.

Behaviour:
- Reset (rst_n=0 at posedge): s1/s2 valid=0, out_valid=0, out_sum=0, out_mode=0, out_ch=0, txn_cnt=0, all accumulators=0. in_ready=0 during the reset cycle.
- Pipeline: two stages, S1 = input register, S2 = output register.
  - Accept on in_valid&&in_ready; output completes on out_valid&&out_ready.
  - Latency: accepted at edge N → out_valid=1 after edge N+1.
  - Throughput: 1/cycle while out_ready=1.
- Advance rule: adv = !s2_valid || out_ready. S1→S2 moves on adv. in_ready = !s1_valid || adv (pure function of registered state and out_ready; no path from in_valid).
- Stall: when out_ready=0, S2 holds out_* stable. S1 holds. in_ready drops once S1 is full. No data lost or duplicated.
- Arithmetic, computed on the S1→S2 move:
  - ADD: zero-extended a+b; carry lands in bit W.
  - SUB: {1'b0,a}-{1'b0,b} modulo 2^(W+1). Bit W set means borrow, e.g. W=8, 3-5 → 9'h1FE.
  - ACC: acc[ch] ← acc[ch]+zext(a), wrapping modulo 2^(W+1); out_sum = new value.
  - CLR: out_sum = old acc[ch]; acc[ch] ← 0.
- Accumulator update: committed on the same edge as the S1→S2 move. Back-to-back ACC/CLR to the same channel therefore sees the prior result with no bubble.
- in_ch ≥ NCH (non-power-of-2 NCH): transaction is treated as ADD of 0 (out_sum=0), no accumulator is touched, and it is still counted.
- txn_cnt: +1 per output handshake; wraps at 2^CNTW.
- Reset mid-operation: in-flight S1/S2 transactions are discarded, no output handshake occurs, and accumulators clear.
- Simultaneous in-accept and out-complete in the same cycle is legal; both take effect.

Optional Feature:
- Macro: VPI_ADDER_ACC_SAT_EN.
- Defined: ACC mode saturates at 2^(W+1)-1 instead of wrapping. A 1-bit output acc_sat is added, asserted with out_valid when the result clamped; it resets to 0.
- Undefined: ACC wraps; acc_sat port is absent.

Decomposition:
- Package vpi_adder_pkg:
  - mode enum MODE_ADD/SUB/ACC/CLR (2 bits).
  - Localparam helper for CHW.
- Sub-module vpi_acc_bank (NCH × (W+1) registers):
  - One read port, one write port.
  - Synchronous active-low clear.
  - Saturation logic under the macro.
- The pipeline/handshake stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, txn_cnt=0, in_ready=0; first accept on the cycle after release.
- ADD/SUB (W=8): a=8'hFF, b=8'h01, ADD → out_sum=9'h100 two cycles later. a=3, b=5, SUB → 9'h1FE.
- ACC/CLR: ACC ch2 with a=10,20,30 back-to-back with no stalls → out_sum 10,30,60 on consecutive cycles. CLR ch2 → 60, then ACC ch2 a=1 → 1. ch0 stays 0.
- Backpressure: stream 6 ADDs while out_ready is held low for 4 cycles → in_ready drops after S1 fills, out_sum holds stable, all 6 results arrive in order, txn_cnt=6.
- Wrap/saturate: ACC ch1 a=255 three times (W=8) → 255, 510, 253 (wrap). With VPI_ADDER_ACC_SAT_EN → 255, 510, 511 with acc_sat=1 on the third.
- Mid-flight reset: accept 2 transactions, pulse rst_n=0 for 1 cycle → no out_valid, txn_cnt=0, prior accumulator contents read back 0 via CLR.
